// File: rtl/fifo_flops_v2_pkg.sv
// Shared types and helpers for the fifo_flops_v2 FIFO family.
package fifo_v2_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_BITS  = 16;

    // Snapshot of every status flag, used by the top to bundle its outputs
    // and available to checkers or scoreboards.
    typedef struct packed {
        logic full;
        logic pndng;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Width that can hold every value 0..depth inclusive.
    function automatic int clog2_plus1(input int depth);
        int width;
        width = 1;
        while ((1 << width) < (depth + 1)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/fifo_flops_v2_ptr.sv
// Wrapping FIFO pointer: advances by one when enabled, wraps from depth-1
// back to 0 so that any integer depth works, not just powers of two.
module fifo_v2_ptr #(
    parameter  int depth = 8,
    localparam int PW    = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST_IDX = PW'(depth - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer value with an explicit wrap at the last entry.
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == LAST_IDX) ? '0 : (ptr_q + PW'(1));
        end
    end

    // Pointer register; reset returns it to entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flops_v2.sv
// Flop-based synchronous FIFO with arbitrary depth, occupancy count,
// almost-full/almost-empty thresholds, sticky error flags and a choice of
// registered-pop or first-word-fall-through read port.
module fifo_flops_v2
    import fifo_v2_pkg::*;
#(
    parameter  int depth    = DEF_DEPTH,
    parameter  int bits     = DEF_BITS,
    parameter  int AF_LEVEL = depth - 1,
    parameter  int AE_LEVEL = 1,
    parameter  int FWFT     = 0,
    localparam int CW       = clog2_plus1(depth),
    localparam int PW       = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] Din,
    input  logic            push,
    input  logic            pop,
    input  logic            clr_err,
    output logic [bits-1:0] Dout,
    output logic            full,
    output logic            pndng,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            underflow
);

    // Parameter sanity checks at elaboration time.
    if (depth < 2) begin : g_bad_depth
        $error("fifo_flops_v2: depth must be at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > depth)) begin : g_bad_af
        $error("fifo_flops_v2: AF_LEVEL must lie in 1..depth");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > depth - 1)) begin : g_bad_ae
        $error("fifo_flops_v2: AE_LEVEL must lie in 0..depth-1");
    end

    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [bits-1:0] mem [depth];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            overflow_q;
    logic            overflow_d;
    logic            underflow_q;
    logic            underflow_d;
    logic            push_ok;
    logic            pop_ok;
    logic            wr_en;
    logic            rd_en;
    fifo_status_t    status;

    // Handshake qualification. A pop needs data; a push needs room, where a
    // simultaneous accepted pop frees the slot it would otherwise lack.
    // Reset overrides every request in its cycle.
    always_comb begin
        pop_ok  = pop & (count_q != '0);
        push_ok = push & ((count_q != DEPTH_C) | pop_ok);
        wr_en   = push_ok & ~rst;
        rd_en   = pop_ok & ~rst;
    end

    fifo_v2_ptr #(.depth(depth)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_en),
        .ptr (wr_ptr)
    );

    fifo_v2_ptr #(.depth(depth)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_en),
        .ptr (rd_ptr)
    );

    // Storage write; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= Din;
        end
    end

    // Occupancy: +1 on push alone, -1 on pop alone, unchanged otherwise.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky error flags: a new refusal sets the flag even when clr_err is
    // asserted in the same cycle.
    always_comb begin
        overflow_d  = (push & ~push_ok) | (overflow_q & ~clr_err);
        underflow_d = (pop & ~pop_ok) | (underflow_q & ~clr_err);
    end

    // Occupancy and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Read port: registered on pop, or a direct view of the head entry.
    if (FWFT == 0) begin : g_reg_pop
        logic [bits-1:0] dout_q;
        logic [bits-1:0] dout_d;

        // Load the head word only on an accepted pop; hold otherwise.
        always_comb begin
            dout_d = dout_q;
            if (pop_ok) begin
                dout_d = mem[rd_ptr];
            end
        end

        // Output data register.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign Dout = dout_q;
    end else begin : g_fwft
        // Head word is shown while the FIFO holds data; zero when empty.
        always_comb begin
            Dout = '0;
            if (count_q != '0) begin
                Dout = mem[rd_ptr];
            end
        end
    end

    // Status flags derived from the registered occupancy.
    always_comb begin
        status.full         = (count_q == DEPTH_C);
        status.pndng        = (count_q != '0);
        status.almost_full  = (count_q >= AF_C);
        status.almost_empty = (count_q <= AE_C);
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
    end

    assign full         = status.full;
    assign pndng        = status.pndng;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign count        = count_q;

endmodule
